// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder: FSM states, mode encodings
// and a width-bounded one-hot generator.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int ONEHOT_MAX = 256;

    // Indices at or beyond width yield all-zero, so callers never see a stray bit.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx, input int width);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx >= 0 && idx < width && idx < ONEHOT_MAX) begin
            v = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control and one-hot output bundle of the scan decoder; master drives the
// select/mode side, slave is the decoder.
interface scan_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
);
    logic               en;
    logic               mode;
    logic               sel_valid;
    logic               sel_ready;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic               out_valid;
    logic [SEL_W-1:0]   cur_idx;
    logic               wrap;
    logic               err;

    modport master (
        output en, mode, sel_valid, sel, dwell,
        input  sel_ready, out, out_valid, cur_idx, wrap, err
    );

    modport slave (
        input  en, mode, sel_valid, sel, dwell,
        output sel_ready, out, out_valid, cur_idx, wrap, err
    );
endinterface

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter timing how long each scan line stays lit; expire is
// combinational and rises once the loaded count has run down to zero.
module scan_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0) & ~clear;

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with handshaked direct selects or a timed
// scan sweep; one cycle input-to-output, sel_ready is en & ~mode (no stalls).
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    scan_decoder_if.slave bus
);
    localparam int               SEL_W1   = SEL_W + 1;
    localparam logic [SEL_W:0]   LINES    = SEL_W1'(OUT_W);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   out_q, out_nxt;
    logic               vld_q, vld_nxt;
    logic [SEL_W-1:0]   idx_q, idx_nxt;
    logic               wrap_q, wrap_nxt;
    logic               err_q, err_nxt;
    logic [DWELL_W-1:0] hold_q, hold_nxt;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_load;
    logic               expire;
    logic               scan_go, direct_go, xfer, sel_oob;

    function automatic logic [OUT_W-1:0] line_of(input logic [SEL_W-1:0] i);
        return OUT_W'(onehot(int'(i), OUT_W));
    endfunction

    assign scan_go   = bus.en & (bus.mode == MODE_SCAN);
    assign direct_go = bus.en & (bus.mode == MODE_DIRECT);
    assign xfer      = bus.sel_valid & direct_go;
    assign sel_oob   = {1'b0, bus.sel} >= LINES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Target state depends only on en/mode, so the mode change always wins over a dwell expiry.
    always_comb begin
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else if (bus.mode == MODE_SCAN) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = DIRECT;
        end
    end

    always_comb begin
        out_nxt  = out_q;
        vld_nxt  = vld_q;
        idx_nxt  = idx_q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        hold_nxt = hold_q;
        tmr_load = 1'b0;
        tmr_val  = hold_q;
        case (state_nxt)
            DIRECT: begin
                if (state == SCAN) begin
                    out_nxt = '0;
                    vld_nxt = 1'b0;
                end
                if (xfer) begin
                    if (sel_oob) begin
                        out_nxt = '0;
                        vld_nxt = 1'b0;
                        err_nxt = 1'b1;
                    end else begin
                        out_nxt = line_of(bus.sel);
                        vld_nxt = 1'b1;
                        idx_nxt = bus.sel;
                    end
                end
            end
            SCAN: begin
                if (state != SCAN) begin
                    idx_nxt  = '0;
                    out_nxt  = line_of('0);
                    vld_nxt  = 1'b1;
                    hold_nxt = bus.dwell;
                    tmr_load = 1'b1;
                    tmr_val  = bus.dwell;
                end else if (expire) begin
                    tmr_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // dwell is only resampled at the wrap, never mid-sweep
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                        hold_nxt = bus.dwell;
                        tmr_val  = bus.dwell;
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                    out_nxt = line_of(idx_nxt);
                end
            end
            default: begin
                out_nxt = '0;
                vld_nxt = 1'b0;
                idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            out_q  <= out_nxt;
            vld_q  <= vld_nxt;
            idx_q  <= idx_nxt;
            wrap_q <= wrap_nxt;
            err_q  <= err_nxt;
            hold_q <= hold_nxt;
        end
    end

    scan_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (~scan_go),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire)
    );

    assign bus.sel_ready = direct_go;
    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.cur_idx   = idx_q;
    assign bus.wrap      = wrap_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: an 8-line and a 6-line instance share stimulus and
// are each compared every cycle against a cycle-level behavioural model.
module tb_scan_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       sv = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] dwell = 8'd0;

    scan_decoder_if #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) b8 ();
    scan_decoder_if #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) b6 ();

    assign b8.en = en;  assign b8.mode = mode;  assign b8.sel_valid = sv;
    assign b8.sel = sel; assign b8.dwell = dwell;
    assign b6.en = en;  assign b6.mode = mode;  assign b6.sel_valid = sv;
    assign b6.sel = sel; assign b6.dwell = dwell;

    scan_decoder #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    scan_decoder #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: device 0 has 8 lines, device 1 has 6.
    int m_lines [2] = '{8, 6};
    bit m_vld   [2];
    int m_cur   [2];
    bit m_wrap  [2];
    bit m_err   [2];
    bit m_scan  [2];
    int m_shown [2];
    int m_dw    [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 0; m_cur[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
            m_scan[k] = 0; m_shown[k] = 0; m_dw[k] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            m_err[k]  = 0;
            if (!en) begin
                m_vld[k] = 0; m_cur[k] = 0; m_scan[k] = 0;
            end else if (mode) begin
                if (!m_scan[k]) begin
                    m_vld[k] = 1; m_cur[k] = 0; m_dw[k] = int'(dwell);
                    m_shown[k] = 0; m_scan[k] = 1;
                end else begin
                    m_shown[k] = m_shown[k] + 1;
                    if (m_shown[k] == m_dw[k] + 1) begin
                        m_shown[k] = 0;
                        m_cur[k] = (m_cur[k] + 1) % m_lines[k];
                        if (m_cur[k] == 0) begin
                            m_wrap[k] = 1;
                            m_dw[k] = int'(dwell);
                        end
                    end
                end
            end else begin
                if (m_scan[k]) m_vld[k] = 0;
                m_scan[k] = 0;
                if (sv) begin
                    if (int'(sel) < m_lines[k]) begin
                        m_cur[k] = int'(sel); m_vld[k] = 1;
                    end else begin
                        m_vld[k] = 0; m_err[k] = 1;
                    end
                end
            end
        end
    endfunction

    // {out, out_valid, cur_idx, wrap, err, sel_ready}
    function automatic logic [14:0] exp_vec(int k);
        logic [7:0] o;
        o = m_vld[k] ? 8'(1 << m_cur[k]) : 8'h00;
        return {o, m_vld[k], 3'(m_cur[k]), m_wrap[k], m_err[k], en & ~mode};
    endfunction

    function automatic logic [14:0] obs_vec(int k);
        if (k == 0) return {b8.out, b8.out_valid, b8.cur_idx, b8.wrap, b8.err, b8.sel_ready};
        return {2'b00, b6.out, b6.out_valid, b6.cur_idx, b6.wrap, b6.err, b6.sel_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #5;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL reset dev%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_direct_sweep();
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sv = 1'b1; sel = 3'(i);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL direct_sweep sel=%0d dev%0d got=%h want=%h", i, k, obs_vec(k), exp_vec(k));
                end
            end
        end
        sv = 1'b0;
    endtask

    task automatic test_out_of_range();
        en = 1'b1; mode = 1'b0; sv = 1'b1; sel = 3'd6;
        tick();
        n_cmp++;
        if (b6.err !== 1'b1 || b6.out !== 6'd0 || b6.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_sel6 got err=%b out=%b vld=%b want err=1 out=000000 vld=0", b6.err, b6.out, b6.out_valid);
        end
        sv = 1'b0;
        tick();
        n_cmp++;
        if (b6.err !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_err_one_cycle got err=%b want 0", b6.err);
        end
        sv = 1'b1; sel = 3'd5;
        tick();
        n_cmp++;
        if (b6.out !== 6'b100000 || b6.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_then_sel5 got out=%b vld=%b want 100000 1", b6.out, b6.out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL oob_model dev%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        sv = 1'b0;
    endtask

    task automatic test_scan_dwell2();
        int wraps;
        int wrap_at;
        wraps = 0; wrap_at = -1;
        en = 1'b1; mode = 1'b1; dwell = 8'd2;
        for (int t = 0; t <= 26; t++) begin
            tick();
            if (b8.wrap === 1'b1) begin
                wraps++;
                if (wrap_at < 0) wrap_at = t;
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL scan_dwell2 t=%0d dev%0d got=%h want=%h", t, k, obs_vec(k), exp_vec(k));
                end
            end
        end
        n_cmp++;
        if (wraps != 1 || wrap_at != 24) begin
            n_bad++;
            $display("FAIL scan_wrap_timing got wraps=%0d at=%0d want 1 at 24", wraps, wrap_at);
        end
    endtask

    task automatic test_dwell_change();
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; dwell = 8'd0;
        for (int t = 0; t < 60; t++) begin
            if (t == 3) dwell = 8'd3;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL dwell_change t=%0d dev%0d got=%h want=%h", t, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; dwell = 8'd0;
        for (int t = 0; t < 5; t++) tick();
        n_cmp++;
        if (b8.cur_idx !== 3'd4 || b8.out !== 8'h10) begin
            n_bad++;
            $display("FAIL en_drop_pre got idx=%0d out=%h want 4 10", b8.cur_idx, b8.out);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (b8.out !== 8'h00 || b8.out_valid !== 1'b0 || b8.cur_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL en_drop_idle got out=%h vld=%b idx=%0d want 00 0 0", b8.out, b8.out_valid, b8.cur_idx);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (b8.out !== 8'h01 || b8.out_valid !== 1'b1 || b8.cur_idx !== 3'd0 || b8.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL en_restart got out=%h vld=%b idx=%0d wrap=%b want 01 1 0 0",
                     b8.out, b8.out_valid, b8.cur_idx, b8.wrap);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = 1'b1; dwell = 8'd1;
        for (int t = 0; t < 7; t++) tick();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL async_reset dev%0d got=%h want=%h", k, obs_vec(k), exp_vec(k));
            end
        end
        mode = 1'b0;
        #1;
        n_cmp++;
        if (b8.sel_ready !== 1'b1 || b8.out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_sel_ready got rdy=%b out=%h want 1 00", b8.sel_ready, b8.out);
        end
        mode = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL async_restart t=%0d dev%0d got=%h want=%h", t, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_random_mix();
        for (int t = 0; t < 600; t++) begin
            en    = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sv    = 1'($urandom_range(0, 1));
            sel   = 3'($urandom_range(0, 7));
            dwell = 8'($urandom_range(0, 3));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL random t=%0d dev%0d got=%h want=%h", t, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct_sweep();
        test_out_of_range();
        test_scan_dwell2();
        test_dwell_change();
        test_en_drop();
        test_async_reset();
        test_random_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised binary-to-one-hot decoder, successor to the fixed 3-to-8 combinational decoder. Output is registered. Two modes:
- Direct: selects are accepted over a valid/ready handshake.
- Scan: an internal counter walks the one-hot output across all lines, holding each line for a programmable dwell time.

Used for row/column strobing (LED matrix, keypad scan) and chip-select fan-out.

Parameters:
SEL_W, 3, select width in bits.
OUT_W, 8, number of one-hot output lines; legal range 2 <= OUT_W <= 2**SEL_W.
DWELL_W, 8, width of the dwell-count input.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  block enable; low forces outputs off.
mode  in  1  0 = direct, 1 = scan.
sel_valid  in  1  direct-mode select valid.
sel_ready  out  1  direct-mode select ready; combinational, equals en & ~mode.
sel  in  SEL_W  binary select.
dwell  in  DWELL_W  scan hold per line, in cycles minus one.
out  out  OUT_W  registered one-hot output.
out_valid  out  1  out holds a valid one-hot code.
cur_idx  out  SEL_W  index of the line currently asserted.
wrap  out  1  one-cycle pulse when the scan returns to index 0.
err  out  1  one-cycle pulse when an out-of-range select is accepted.

Behaviour:
Reset (rst_n low, asynchronous):
- out=0, out_valid=0, cur_idx=0, wrap=0, err=0.
- FSM goes to IDLE; dwell counter cleared.

FSM states: IDLE, DIRECT, SCAN.
- IDLE -> DIRECT when en & ~mode.
- IDLE -> SCAN when en & mode.
- DIRECT <-> SCAN follows mode; the change takes effect on the next edge.
- Any state -> IDLE when en is low; this has priority over everything else.

IDLE:
- Registered outputs clear on the edge after en falls: out=0, out_valid=0, cur_idx=0.
- Dwell counter is cleared.

Direct handshake:
- A transfer occurs on an edge where sel_valid & sel_ready.
- Latency is one cycle: after the transfer edge, out=1<<sel, cur_idx=sel, out_valid=1.
- If sel >= OUT_W: out=0, out_valid=0, cur_idx unchanged, err=1 for exactly one cycle.
- out holds until the next accepted select, a mode change, or en falling.
- On SCAN->DIRECT: out=0 and out_valid=0 until the first accepted select.

Scan:
- On entry (from IDLE or DIRECT): next edge gives out=1<<0, cur_idx=0, out_valid=1. wrap is NOT pulsed at entry.
- dwell is sampled at entry and at every wrap; mid-sweep changes are ignored.
- Each index is held for dwell+1 cycles. dwell=0 advances every cycle.
- After index OUT_W-1, the scan returns to index 0 and wrap=1 on the same cycle out shows index 0.
- sel_valid is ignored and no transfer occurs, because sel_ready=0.

Width rules:
- One-hot generation is masked to OUT_W bits.
- Comparisons use SEL_W-bit unsigned values.
- The scan counter wraps at OUT_W-1, not at 2**SEL_W-1.

Simultaneous events:
- en low together with any other input: IDLE wins.
- A mode change on the same edge as a dwell expiry: the mode change wins, and the scan index does not advance.

Invariant: out is one-hot when out_valid=1 and all-zero otherwise.

Decomposition:
- scan_decoder_pkg: state enum {IDLE, DIRECT, SCAN}; MODE_DIRECT/MODE_SCAN constants; one-hot helper function onehot(idx, width).
- One sub-module, scan_dwell_timer:
  - Loadable down-counter, DWELL_W bits.
  - Inputs: load, load value, clear.
  - Output: expire pulse.
  - Resets to 0 on rst_n.

Test Plan:
- Default params, en=1, mode=0, apply sel=0..7 with sel_valid each cycle -> out=0x01,0x02,...,0x80 one cycle after each transfer; out_valid=1; cur_idx tracks sel.
- OUT_W=6, SEL_W=3, direct select sel=6 -> out=0, out_valid=0, err high exactly one cycle; then sel=5 -> out=6'b100000.
- Scan, OUT_W=8, dwell=2 -> each line held 3 cycles, order 0..7; wrap pulses once when index 0 reappears 24 cycles after entry; no wrap at entry.
- Scan with dwell=0, change dwell to 3 mid-sweep -> stride stays 1 cycle until wrap, then 4 cycles per line.
- Scan at index 4, deassert en -> next edge out=0, out_valid=0, cur_idx=0; reassert en -> restart at index 0.
- Assert rst_n low asynchronously mid-scan between edges -> outputs clear immediately without a clock edge; after release the sweep restarts at index 0 and sel_ready=en&~mode throughout.
